// File: rtl/ttrng_conditioner.sv
// rtl/ttrng_conditioner.sv - raw bit sync, von Neumann extractor and byte packer for the TRNG.
// Optional repetition-count health test enabled by TTRNG_RCT_HEALTH_EN.
module ttrng_conditioner #(
  parameter int SAMPLE_DIV = 4,
  parameter int RCT_LIMIT  = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       raw_bit,
  input  logic       bypass,
  output logic [7:0] number,
  output logic       number_valid,
  output logic       alarm
);

  localparam logic [0:0] ST_FIRST  = 1'b0;
  localparam logic [0:0] ST_SECOND = 1'b1;
  localparam logic [7:0] DIV_MAX   = 8'(SAMPLE_DIV - 1);

  logic       r_sync1;
  logic       r_sync2;
  logic [7:0] r_div;
  logic [0:0] r_state;
  logic       r_a;
  logic       r_byp_q;
  logic [6:0] r_shift;
  logic [2:0] r_cnt;
  logic [7:0] r_number;
  logic       r_valid;

  logic w_strobe;
  logic w_sample;
  logic w_byp_chg;
  logic w_emit;
  logic w_bit;
  logic w_pack;
  logic w_alarm;

  assign w_strobe  = ena && (r_div == DIV_MAX);
  assign w_sample  = r_sync2;
  assign w_byp_chg = bypass ^ r_byp_q;
  assign w_pack    = w_emit && !w_alarm;

  always_comb begin
    w_emit = 1'b0;
    w_bit  = w_sample;
    if (w_strobe) begin
      if (bypass) begin
        w_emit = 1'b1;
      end else if (!w_byp_chg && (r_state == ST_SECOND) && (w_sample != r_a)) begin
        w_emit = 1'b1;
        w_bit  = r_a;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_div   <= 8'd0;
      r_byp_q <= 1'b0;
    end else begin
      r_sync1 <= raw_bit;
      r_sync2 <= r_sync1;
      r_byp_q <= bypass;
      if (ena) begin
        r_div <= (r_div == DIV_MAX) ? 8'd0 : r_div + 8'd1;
      end
    end
  end

  // A bypass change or ena drop abandons any half-collected pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_FIRST;
      r_a     <= 1'b0;
    end else if (!ena || bypass || w_byp_chg) begin
      r_state <= ST_FIRST;
    end else if (w_strobe) begin
      if (r_state == ST_FIRST) begin
        r_a     <= w_sample;
        r_state <= ST_SECOND;
      end else begin
        r_state <= ST_FIRST;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift  <= 7'd0;
      r_cnt    <= 3'd0;
      r_number <= 8'd0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_pack) begin
        if (r_cnt == 3'd7) begin
          r_number <= {r_shift, w_bit};
          r_valid  <= 1'b1;
          r_cnt    <= 3'd0;
        end else begin
          r_shift <= {r_shift[5:0], w_bit};
          r_cnt   <= r_cnt + 3'd1;
        end
      end
    end
  end

`ifdef TTRNG_RCT_HEALTH_EN
  localparam logic [7:0] RCT_MAX = 8'(RCT_LIMIT);

  logic [7:0] r_run;
  logic       r_last;
  logic       r_alarm;
  logic [7:0] w_run_next;

  always_comb begin
    w_run_next = r_run;
    if ((r_run == 8'd0) || (w_sample != r_last)) begin
      w_run_next = 8'd1;
    end else if (r_run < RCT_MAX) begin
      w_run_next = r_run + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run   <= 8'd0;
      r_last  <= 1'b0;
      r_alarm <= 1'b0;
    end else if (w_strobe) begin
      r_run  <= w_run_next;
      r_last <= w_sample;
      if (w_run_next == RCT_MAX) begin
        r_alarm <= 1'b1;
      end
    end
  end

  assign w_alarm = r_alarm;
`else
  assign w_alarm = 1'b0;
`endif

  assign alarm        = w_alarm;
  assign number       = w_alarm ? 8'd0 : r_number;
  assign number_valid = r_valid & ~w_alarm;

endmodule

// File: tb/tb_ttrng_conditioner.sv
// tb/tb_ttrng_conditioner.sv - self-checking bench for ttrng_conditioner (SAMPLE_DIV 1 and 4 instances).
module tb_ttrng_conditioner;

  localparam int RCT = 32;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       raw_bit;
  logic       bypass;
  logic [7:0] number1, number4;
  logic       valid1, valid4;
  logic       alarm1, alarm4;

  ttrng_conditioner #(.SAMPLE_DIV(1), .RCT_LIMIT(RCT)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .raw_bit(raw_bit), .bypass(bypass),
    .number(number1), .number_valid(valid1), .alarm(alarm1)
  );

  ttrng_conditioner #(.SAMPLE_DIV(4), .RCT_LIMIT(RCT)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .raw_bit(raw_bit), .bypass(bypass),
    .number(number4), .number_valid(valid4), .alarm(alarm4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp;
  int n_fail;

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: integer divider phase, pending-half-pair value (-1 = none),
  // and a byte accumulator where each new bit doubles the running value.
  int         divs [2] = '{1, 4};
  int         m_div [2];
  int         m_pend [2];
  int         m_cnt [2];
  int         m_acc [2];
  logic [7:0] m_num [2];
  logic       m_val [2];
  int         m_run [2];
  int         m_last [2];
  logic       m_alarm [2];
  int         m_s1, m_s2, m_pbyp;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_div[i] = 0; m_pend[i] = -1; m_cnt[i] = 0; m_acc[i] = 0;
      m_num[i] = 8'd0; m_val[i] = 1'b0; m_run[i] = 0; m_last[i] = 0; m_alarm[i] = 1'b0;
    end
    m_s1 = 0; m_s2 = 0; m_pbyp = 0;
  endtask

  task automatic model_step(input int raw, input int en, input int byp);
    for (int i = 0; i < 2; i++) begin
      bit strobe;
      bit emit;
      int eb;
      strobe = (en != 0) && (m_div[i] == divs[i] - 1);
      if (en != 0) m_div[i] = (m_div[i] == divs[i] - 1) ? 0 : m_div[i] + 1;
      emit = 1'b0;
      eb = 0;
      if (en == 0) begin
        m_pend[i] = -1;
      end else if (byp != 0) begin
        m_pend[i] = -1;
        if (strobe) begin emit = 1'b1; eb = m_s2; end
      end else if (byp != m_pbyp) begin
        m_pend[i] = -1;
      end else if (strobe) begin
        if (m_pend[i] < 0) begin
          m_pend[i] = m_s2;
        end else begin
          if (m_s2 != m_pend[i]) begin emit = 1'b1; eb = m_pend[i]; end
          m_pend[i] = -1;
        end
      end
      m_val[i] = 1'b0;
      if (emit && !m_alarm[i]) begin
        m_acc[i] = m_acc[i] * 2 + eb;
        m_cnt[i]++;
        if (m_cnt[i] == 8) begin
          m_num[i] = 8'(m_acc[i]);
          m_val[i] = 1'b1;
          m_cnt[i] = 0;
          m_acc[i] = 0;
        end
      end
`ifdef TTRNG_RCT_HEALTH_EN
      if (strobe) begin
        if (m_run[i] == 0 || m_s2 != m_last[i]) m_run[i] = 1;
        else if (m_run[i] < RCT) m_run[i]++;
        m_last[i] = m_s2;
        if (m_run[i] == RCT) m_alarm[i] = 1'b1;
      end
`endif
    end
    m_pbyp = byp;
    m_s2 = m_s1;
    m_s1 = raw;
  endtask

  task automatic step(input int raw, input int en, input int byp);
    raw_bit = raw[0];
    ena     = en[0];
    bypass  = byp[0];
    model_step(raw, en, byp);
    @(posedge clk);
    #1;
    check("number1", number1, m_alarm[0] ? 0 : m_num[0]);
    check("valid1",  valid1,  m_val[0] && !m_alarm[0]);
    check("alarm1",  alarm1,  m_alarm[0]);
    check("number4", number4, m_alarm[1] ? 0 : m_num[1]);
    check("valid4",  valid4,  m_val[1] && !m_alarm[1]);
    check("alarm4",  alarm4,  m_alarm[1]);
  endtask

  // Asserts reset between edges and checks the outputs clear without a clock.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_number1", number1, 0);
    check("rst_valid1",  valid1,  0);
    check("rst_alarm1",  alarm1,  0);
    check("rst_number4", number4, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // samp/en hold one entry per cycle, first cycle at bit n-1; raw leads the sample by 2 syncs.
  task automatic run_seq(input int byp, input int n, input logic [63:0] samp,
                         input logic [63:0] en, output int pulses);
    pulses = 0;
    step(samp[n-1], 0, byp);
    step(samp[n-2], 0, byp);
    for (int k = 0; k < n; k++) begin
      step((k + 2 < n) ? int'(samp[n-1-(k+2)]) : 0, en[n-1-k], byp);
      if (valid1) pulses++;
    end
  endtask

  typedef struct {
    int          byp;
    int          n;
    logic [63:0] samp;
    logic [63:0] en;
    logic [7:0]  exp_num;
    int          exp_pulses;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int pulses;
    n_cmp  = 0;
    n_fail = 0;

    tbl[0] = '{1, 8,  64'(8'b10110010), '1, 8'hB2, 1};
    tbl[1] = '{0, 20, 64'(20'b10_01_11_00_10_10_01_01_10_01), '1, 8'hB2, 1};
    tbl[2] = '{1, 8,  64'(8'b01011010), '1, 8'h5A, 1};
    tbl[3] = '{0, 16, 64'(16'b01_01_01_01_10_10_10_10), '1, 8'h0F, 1};
    tbl[4] = '{0, 37, 64'({8'b10_01_10_10, 1'b1, 20'd0, 8'b01_01_10_01}),
               64'({9'h1FF, 20'd0, 8'hFF}), 8'hB2, 1};
    tbl[5] = '{0, 64, 64'd0, '1, 8'h00, 0};

    rst_n = 1'b0; ena = 1'b0; raw_bit = 1'b0; bypass = 1'b0;
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("init_number1", number1, 0);
    check("init_valid1",  valid1,  0);
    rst_n = 1'b1;

    for (int t = 0; t < 6; t++) begin
      do_reset();
      run_seq(tbl[t].byp, tbl[t].n, tbl[t].samp, tbl[t].en, pulses);
      check($sformatf("vec%0d_number", t), number1, tbl[t].exp_num);
      check($sformatf("vec%0d_pulses", t), pulses, tbl[t].exp_pulses);
      for (int k = 0; k < 4; k++) step(0, 0, tbl[t].byp);
    end

    // Mid-stream reset: partial byte and last byte are both lost.
    do_reset();
    for (int k = 0; k < 300; k++) step($urandom_range(0, 1), 1, 1);
    do_reset();
    check("after_rst_number1", number1, 0);

    // Randomized traffic with ena gaps and occasional bypass flips.
    begin
      int byp;
      byp = 0;
      for (int k = 0; k < 3000; k++) begin
        if ($urandom_range(0, 49) == 0) byp = 1 - byp;
        step($urandom_range(0, 1), ($urandom_range(0, 7) != 0) ? 1 : 0, byp);
      end
    end

`ifdef TTRNG_RCT_HEALTH_EN
    do_reset();
    for (int k = 0; k < 40; k++) step(1, 1, 0);
    check("rct_alarm1", alarm1, 1);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      step(k % 2, 1, (k / 20) % 2);
      if (valid1) pulses++;
    end
    check("rct_pulses", pulses, 0);
    check("rct_number1", number1, 0);
    check("rct_alarm1_hold", alarm1, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
